// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT/INTT/point-wise datapath: operating-mode
// and write-FSM state encodings plus the default lane and width constants.
package ntt_pkg;

  // Datapath operating mode; the reserved encoding 2'd3 maps to MODE_NTT on latch.
  typedef enum logic [1:0] {
    MODE_NTT  = 2'd0,
    MODE_INTT = 2'd1,
    MODE_PWM  = 2'd2
  } mode_e;

  // Write-side pass sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_BFU_NUM = 4;
  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_CNT_W   = 7;
  localparam int unsigned DEF_BF_LAT  = 11;

endpackage : ntt_pkg

// File: rtl/bank_wr_addr_gen_param_shifter.sv
// Fixed-depth shift-register delay line with asynchronous clear.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (clears every stage)
//   din        : data entering the line
//   dout       : data after exactly `depth` clock edges
module bank_wr_addr_gen_param_shifter #(
  parameter int unsigned data_width = 9,
  parameter int unsigned depth      = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [data_width-1:0] din,
  output logic [data_width-1:0] dout
);

  logic [data_width-1:0] stage [depth];

  // Stage 0 captures the input; every later stage copies its predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < depth; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < depth; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[depth-1];

endmodule : bank_wr_addr_gen_param_shifter

// File: rtl/bank_wr_addr_gen_param.sv
// Parametrised bank write-address generator. Issue tokens from the read-side
// scheduler are delayed by the butterfly latency; each delayed token drives one
// address and one write enable per bank (NB = 2*BFU_NUM) plus an end-of-pass
// pulse. A small sequencer tracks the pass and gates acceptance while draining.
// Optional build macro BWAG_OUT_REG_EN: registers addr_w, wen and pass_done
// (one extra cycle of latency; busy then tracks the registered pass_done).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   issue_valid : issue token present
//   issue_cnt   : butterfly-group index of the token
//   issue_last  : token is the final one of the pass
//   mode        : 0=NTT, 1=INTT, 2=PWM, 3=reserved (NTT); latched at pass start
//   addr_w      : per-bank address, lane k at [k*ADDR_W +: ADDR_W]
//   wen         : per-bank write enable
//   pass_done   : one-cycle pulse alongside the final write of a pass
//   busy        : pass in flight
module bank_wr_addr_gen_param
  import ntt_pkg::*;
#(
  parameter int unsigned BFU_NUM = DEF_BFU_NUM,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned BF_LAT  = DEF_BF_LAT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  input  logic [CNT_W-1:0]            issue_cnt,
  input  logic                        issue_last,
  input  logic [1:0]                  mode,
  output logic [2*BFU_NUM*ADDR_W-1:0] addr_w,
  output logic [2*BFU_NUM-1:0]        wen,
  output logic                        pass_done,
  output logic                        busy
);

  localparam int unsigned NB = 2 * BFU_NUM;
  localparam int unsigned DW = CNT_W + 2;
  localparam logic [ADDR_W-1:0] MSB_BIT = {1'b1, {(ADDR_W-1){1'b0}}};

  state_e state_q, state_d;
  mode_e  mode_q;

  logic              accept_c;
  logic [DW-1:0]     dl_in, dl_out;
  logic              d_valid, d_last;
  logic [CNT_W-1:0]  d_cnt;
  logic [ADDR_W-1:0] cnt_ext, base_n, base_w, hi_w;
  logic [ADDR_W-1:0] lane_addr [NB];
  logic [NB*ADDR_W-1:0] addr_nxt;
  logic [NB*ADDR_W-1:0] addr_q;

  // Tokens arriving while the pass drains are dropped before the delay line.
  assign accept_c = issue_valid & (state_q != ST_DRAIN);
  assign dl_in    = {accept_c, issue_cnt, issue_last};

  bank_wr_addr_gen_param_shifter #(
    .data_width (DW),
    .depth      (BF_LAT)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (dl_in),
    .dout  (dl_out)
  );

  assign d_valid = dl_out[DW-1];
  assign d_cnt   = dl_out[DW-2:1];
  assign d_last  = dl_out[0];

  // Pass sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Pass sequencer next state; DRAIN waits for the (possibly registered) pass_done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (issue_valid) state_d = issue_last ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (issue_valid && issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (pass_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Mode is sampled only on the first accept of a pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_NTT;
    end else if (state_q == ST_IDLE && issue_valid) begin
      unique case (mode)
        2'd1:    mode_q <= MODE_INTT;
        2'd2:    mode_q <= MODE_PWM;
        default: mode_q <= MODE_NTT;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);

  // Shared bases, all modulo 2^ADDR_W.
  assign cnt_ext = ADDR_W'(d_cnt);
  assign base_n  = cnt_ext * ADDR_W'(BFU_NUM);
  assign base_w  = cnt_ext * ADDR_W'(NB);
  assign hi_w    = base_w | MSB_BIT;

  // Per-lane address: lower half and upper half differ only in INTT.
  for (genvar k = 0; k < NB; k++) begin : g_lane
    if (k < BFU_NUM) begin : g_lo
      assign lane_addr[k] = ((mode_q == MODE_NTT) ? base_n : base_w) + ADDR_W'(k);
    end else begin : g_hi
      assign lane_addr[k] = (mode_q == MODE_INTT) ? (hi_w + ADDR_W'(k - BFU_NUM))
                          : (((mode_q == MODE_PWM) ? base_w : base_n) + ADDR_W'(k));
    end
    assign addr_nxt[k*ADDR_W +: ADDR_W] = lane_addr[k];
  end

`ifdef BWAG_OUT_REG_EN
  logic [NB-1:0] wen_q;
  logic          pass_done_q;

  // Registered outputs; the address holds between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wen_q       <= '0;
      pass_done_q <= 1'b0;
    end else begin
      wen_q       <= {NB{d_valid}};
      pass_done_q <= d_valid & d_last;
      if (d_valid) addr_q <= addr_nxt;
    end
  end

  assign addr_w    = addr_q;
  assign wen       = wen_q;
  assign pass_done = pass_done_q;
`else
  // Last written address, presented while the delay-line tail is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       addr_q <= '0;
    else if (d_valid) addr_q <= addr_nxt;
  end

  assign addr_w    = d_valid ? addr_nxt : addr_q;
  assign wen       = {NB{d_valid}};
  assign pass_done = d_valid & d_last;
`endif

endmodule : bank_wr_addr_gen_param
